// File: rtl/key_expand_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_expand_ctrl                                            |
// | Description : Sequences a one-round KeySchedule stage NR times to expand |
// |               an AES-128 key and serves round keys from a register file. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module key_expand_ctrl #(
  parameter int NR = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [127:0]  ks_key,
  output logic [3:0]    ks_rnum,
  output logic          ks_valid_in,
  output logic          ks_key_len,
  input  logic [127:0]  ks_out_key,
  input  logic          ks_valid_out,
  output logic          keys_valid,
  output logic          busy,
  input  logic [AW-1:0] rk_addr,
  output logic [127:0]  rk_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT        r_state;
  stateT        w_nextState;
  logic [127:0] r_curKey;
  logic [3:0]   r_rnum;
  logic [127:0] r_rk [0:NR];
  logic         w_accept;
  logic         w_capture;
  logic         w_lastRound;

  assign w_accept    = key_valid && key_ready;
  assign w_capture   = (r_state == EXPAND) && ks_valid_out;
  assign w_lastRound = (r_rnum == 4'(NR));
  assign ks_key_len  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Stage-facing outputs are forced to zero outside EXPAND so stale round
  // state never leaks onto the KeySchedule inputs.
  always_comb begin
    w_nextState = r_state;
    key_ready   = 1'b0;
    busy        = 1'b0;
    keys_valid  = 1'b0;
    ks_valid_in = 1'b0;
    ks_key      = '0;
    ks_rnum     = '0;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) w_nextState = EXPAND;
      end
      EXPAND: begin
        busy        = 1'b1;
        ks_valid_in = 1'b1;
        ks_key      = r_curKey;
        ks_rnum     = r_rnum;
        if (ks_valid_out && w_lastRound) w_nextState = DONE;
      end
      DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (key_valid) w_nextState = EXPAND;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The final capture leaves the round counter at NR rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curKey <= '0;
      r_rnum   <= '0;
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else if (w_accept) begin
      r_rk[0]  <= key_in;
      r_curKey <= key_in;
      r_rnum   <= 4'd1;
    end else if (w_capture) begin
      r_rk[r_rnum] <= ks_out_key;
      r_curKey     <= ks_out_key;
      if (!w_lastRound) r_rnum <= r_rnum + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data <= '0;
    end else if (int'(rk_addr) <= NR) begin
      rk_data <= r_rk[rk_addr];
    end else begin
      rk_data <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_expand_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_key_expand_ctrl                                         |
// | Description : Bench for key_expand_ctrl with a one-round stage model and |
// |               a word-level FIPS-197 key expansion reference.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_key_expand_ctrl;

  localparam int NR = 10;
  localparam int AW = 4;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  keyIn;
  logic          keyValid;
  logic          keyReady;
  logic [127:0]  ksKey;
  logic [3:0]    ksRnum;
  logic          ksValidIn;
  logic          ksKeyLen;
  logic [127:0]  ksOutKey;
  logic          ksValidOut;
  logic          keysValid;
  logic          busy;
  logic [AW-1:0] rkAddr;
  logic [127:0]  rkData;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [127:0] expKeys [0:NR];

  always #5 clk = ~clk;

  key_expand_ctrl #(.NR(NR), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (keyIn),
    .key_valid    (keyValid),
    .key_ready    (keyReady),
    .ks_key       (ksKey),
    .ks_rnum      (ksRnum),
    .ks_valid_in  (ksValidIn),
    .ks_key_len   (ksKeyLen),
    .ks_out_key   (ksOutKey),
    .ks_valid_out (ksValidOut),
    .keys_valid   (keysValid),
    .busy         (busy),
    .rk_addr      (rkAddr),
    .rk_data      (rkData)
  );

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] subRot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction

  function automatic logic [7:0] rconByte(input int r);
    logic [7:0] c;
    if (r == 0) return 8'h00;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    return c;
  endfunction

  // Behaviour of the external one-round KeySchedule stage
  function automatic logic [127:0] ksStep(input logic [127:0] k, input logic [3:0] rn);
    logic [31:0] t, n0, n1, n2, n3;
    t  = subRot(k[31:0]) ^ {rconByte(int'(rn)), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign ksOutKey = ksStep(ksKey, ksRnum);

  task automatic buildExpected(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) temp = subRot(temp) ^ {rconByte(i / 4), 24'h0};
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= NR; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic runExpansion(input logic [127:0] key, input int stallAt, input int stallLen,
                              input int stallPct, input int pulseAt, input int abortAt);
    int cycles, stalls, expRnum, stallLeft;
    buildExpected(key);
    @(negedge clk);
    checkVal("key_ready_pre", 128'(keyReady), 128'(1));
    keyIn = key; keyValid = 1'b1;
    @(negedge clk);
    keyValid = 1'b0; keyIn = ~key;
    checkVal("kv_after_accept", 128'(keysValid), 128'(0));
    checkVal("busy_expand", 128'(busy), 128'(1));
    checkVal("ks_valid_in", 128'(ksValidIn), 128'(1));
    cycles = 1; stalls = 0; expRnum = 1; stallLeft = stallLen;
    while (!keysValid && cycles < 200) begin
      checkVal("ks_rnum", 128'(ksRnum), 128'(expRnum));
      checkVal("ks_key", ksKey, (expRnum <= NR) ? expKeys[expRnum-1] : '0);
      if (expRnum == abortAt) begin
        rst_n = 1'b0;
        keyValid = 1'b0;
        #1;
        checkVal("abort_kv", 128'(keysValid), 128'(0));
        checkVal("abort_busy", 128'(busy), 128'(0));
        checkVal("abort_ready", 128'(keyReady), 128'(1));
        checkVal("abort_rkdata", rkData, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ksValidOut = 1'b1;
        return;
      end
      if (expRnum == pulseAt) begin
        checkVal("key_ready_busy", 128'(keyReady), 128'(0));
        keyIn = ~key; keyValid = 1'b1;
      end else begin
        keyValid = 1'b0;
      end
      if (expRnum == stallAt && stallLeft > 0) begin
        ksValidOut = 1'b0; stallLeft--;
      end else if (stallPct > 0 && $urandom_range(99) < stallPct) begin
        ksValidOut = 1'b0;
      end else begin
        ksValidOut = 1'b1;
      end
      if (ksValidOut) expRnum++; else stalls++;
      @(negedge clk);
      cycles++;
    end
    keyValid = 1'b0; ksValidOut = 1'b1;
    checkVal("latency", 128'(cycles), 128'(NR + 1 + stalls));
    checkVal("done_busy", 128'(busy), 128'(0));
    checkVal("done_ready", 128'(keyReady), 128'(1));
    checkVal("done_vin", 128'(ksValidIn), 128'(0));
    checkVal("done_rnum", 128'(ksRnum), 128'(0));
  endtask

  task automatic readAt(input string tag, input int a, input logic [127:0] exp);
    @(negedge clk);
    rkAddr = AW'(a);
    @(negedge clk);
    checkVal(tag, rkData, exp);
  endtask

  task automatic checkReadback(input string tag);
    int a;
    for (int i = 0; i < 16; i++) readAt(tag, i, (i <= NR) ? expKeys[i] : '0);
    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(15));
      readAt({tag, "_rand"}, a, (a <= NR) ? expKeys[a] : '0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; keyIn = '0; keyValid = 1'b0; ksValidOut = 1'b1; rkAddr = '0;
    #12;
    checkVal("rst_ready", 128'(keyReady), 128'(1));
    checkVal("rst_kv", 128'(keysValid), 128'(0));
    checkVal("rst_busy", 128'(busy), 128'(0));
    checkVal("rst_vin", 128'(ksValidIn), 128'(0));
    checkVal("rst_rnum", 128'(ksRnum), 128'(0));
    checkVal("rst_keylen", 128'(ksKeyLen), 128'(0));
    checkVal("rst_rkdata", rkData, '0);
    @(negedge clk);
    rst_n = 1'b1;

    runExpansion(FIPS_KEY, 0, 0, 0, 0, 0);
    checkReadback("rk_fips");
    readAt("fips_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    readAt("fips_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    runExpansion(FIPS_KEY, 4, 3, 0, 0, 0);
    checkReadback("rk_stall");

    runExpansion(FIPS_KEY, 0, 0, 0, 0, 6);
    readAt("rk0_cleared", 0, '0);
    runExpansion(FIPS_KEY, 0, 0, 0, 0, 0);
    checkReadback("rk_after_abort");

    runExpansion(KEY2, 0, 0, 0, 0, 0);
    readAt("key2_rk10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    checkReadback("rk_key2");

    runExpansion(FIPS_KEY, 0, 0, 0, 5, 0);
    checkReadback("rk_pulse");

    repeat (6) begin
      runExpansion({$urandom, $urandom, $urandom, $urandom},
                   int'($urandom_range(1, 10)), int'($urandom_range(0, 3)), 20, 0, 0);
      checkReadback("rk_rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
`default_nettype wire
